// File: rtl/csr_counters_if.sv
// csr_counters_if: CSR access bus between the M-stage CSR logic and the
// performance-counter block.
//   CSRWriteM          write strobe (already gated by stall/flush)
//   CSRAdrM            12-bit CSR address
//   CSRWriteValM       write data, XLEN bits
//   PrivilegeModeM     current privilege: 11=M, 01=S, 00=U
//   CSRCReadValM       read data back to the CSR read mux
//   IllegalCSRCAccessM access must raise an illegal-instruction trap
// master: CSR read/write mux side; slave: counter block.
interface csr_counters_if #(
  parameter int XLEN = 64
);
  logic            CSRWriteM;
  logic [11:0]     CSRAdrM;
  logic [XLEN-1:0] CSRWriteValM;
  logic [1:0]      PrivilegeModeM;
  logic [XLEN-1:0] CSRCReadValM;
  logic            IllegalCSRCAccessM;

  modport master (
    output CSRWriteM, CSRAdrM, CSRWriteValM, PrivilegeModeM,
    input  CSRCReadValM, IllegalCSRCAccessM
  );

  modport slave (
    input  CSRWriteM, CSRAdrM, CSRWriteValM, PrivilegeModeM,
    output CSRCReadValM, IllegalCSRCAccessM
  );
endinterface

// File: rtl/csr_counters.sv
// csr_counters: mcycle, minstret and NUM_HPM hpm counters (index 3 and up),
// with machine addresses 0xBxx and user shadows 0xCxx.
//   clk, reset_n        clock, asynchronous active-low reset
//   csr                 CSR access bus (slave modport)
//   MCOUNTINHIBIT_REGW  per-counter increment inhibit
//   MCOUNTEREN_REGW     M-level lower-privilege read enable
//   SCOUNTEREN_REGW     S-level U-mode read enable
//   InstrRetiredM       one instruction retires this cycle
//   HPMEventM           event k increments hpm counter 3+k
// All counters are 64 bits; read data and the illegal flag are combinational.
module csr_counters #(
  parameter int XLEN        = 64,
  parameter int NUM_HPM     = 4,
  parameter bit S_SUPPORTED = 1'b1,
  parameter bit U_SUPPORTED = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  csr_counters_if.slave      csr,
  input  logic [31:0]        MCOUNTINHIBIT_REGW,
  input  logic [31:0]        MCOUNTEREN_REGW,
  input  logic [31:0]        SCOUNTEREN_REGW,
  input  logic               InstrRetiredM,
  input  logic [NUM_HPM-1:0] HPMEventM
);

  logic [3:0]  adr_base;
  logic [4:0]  idx;
  logic        adr_hi;
  logic        is_b;
  logic        is_c;
  logic        in_map;
  logic        shadow_ok;
  logic        illegal;
  logic        wr_en;
  logic [63:0] cnt [32];
  logic [63:0] cur;
  logic [63:0] wr_val;
  logic [XLEN-1:0] rd_val;
  logic        unused_bits;

  assign adr_base = csr.CSRAdrM[11:8];
  assign idx      = csr.CSRAdrM[4:0];
  assign adr_hi   = csr.CSRAdrM[7];
  assign is_b     = (adr_base == 4'hB);
  assign is_c     = (adr_base == 4'hC) && U_SUPPORTED;
  // Served windows are 0x00-0x1F and 0x80-0x9F within each page.
  assign in_map   = (is_b || is_c) && (csr.CSRAdrM[6:5] == 2'b00);

  // Shadow (0xCxx) read permission; reserved privilege 10 is treated like U.
  always_comb begin
    shadow_ok = 1'b0;
    case (csr.PrivilegeModeM)
      2'b11:   shadow_ok = 1'b1;
      2'b01:   shadow_ok = MCOUNTEREN_REGW[idx];
      default: shadow_ok = MCOUNTEREN_REGW[idx] &
                           (S_SUPPORTED ? SCOUNTEREN_REGW[idx] : 1'b1);
    endcase
  end

  // Index 1 (time) lives elsewhere; shadows are never writable.
  assign illegal = !in_map
                || (idx == 5'd1)
                || (adr_hi && (XLEN == 64))
                || (is_b && (csr.PrivilegeModeM != 2'b11))
                || (is_c && (csr.CSRWriteM || !shadow_ok));

  assign wr_en = csr.CSRWriteM && !illegal && is_b;
  assign cur   = cnt[idx];

  generate
    if (XLEN == 64) begin : g_rv64
      assign wr_val = csr.CSRWriteValM;
      assign rd_val = cur;
    end else begin : g_rv32
      // Half write: the other half is held, no carry between halves.
      assign wr_val = adr_hi ? {csr.CSRWriteValM, cur[31:0]}
                             : {cur[63:32], csr.CSRWriteValM};
      assign rd_val = adr_hi ? cur[63:32] : cur[31:0];
    end
  endgenerate

  assign csr.CSRCReadValM       = illegal ? '0 : rd_val;
  assign csr.IllegalCSRCAccessM = illegal;

  generate
    for (genvar i = 0; i < 32; i++) begin : g_cnt
      if (i == 0 || i == 2 || (i >= 3 && i < 3 + NUM_HPM)) begin : g_impl
        logic        inc;
        logic [63:0] cnt_q;
        if (i == 0) begin : g_cyc
          assign inc = ~MCOUNTINHIBIT_REGW[i];
        end else if (i == 2) begin : g_ret
          assign inc = InstrRetiredM & ~MCOUNTINHIBIT_REGW[i];
        end else begin : g_hpm
          assign inc = HPMEventM[i-3] & ~MCOUNTINHIBIT_REGW[i];
        end
        // A write in the same cycle takes priority over the increment.
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            cnt_q <= '0;
          end else if (wr_en && (idx == 5'(i))) begin
            cnt_q <= wr_val;
          end else if (inc) begin
            cnt_q <= cnt_q + 64'd1;
          end
        end
        assign cnt[i] = cnt_q;
      end else begin : g_none
        assign cnt[i] = 64'd0;
      end
    end
  endgenerate

  // Not every enable/inhibit bit has a counter behind it.
  assign unused_bits = ^{MCOUNTINHIBIT_REGW, MCOUNTEREN_REGW, SCOUNTEREN_REGW};

endmodule

// File: tb/tb_csr_counters.sv
module tb_csr_counters;
  localparam int NHPM  = 4;
  localparam bit U_SUP = 1'b1;
  localparam bit S_SUP = 1'b1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr;
  logic [11:0] adr;
  logic [63:0] wval;
  logic [1:0]  priv;
  logic [31:0] inhibit, mcen, scen;
  logic        retired;
  logic [NHPM-1:0] ev;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] m64 [32];
  logic [63:0] m32 [32];

  always #5 clk = ~clk;

  csr_counters_if #(.XLEN(64)) if64 ();
  csr_counters_if #(.XLEN(32)) if32 ();

  assign if64.CSRWriteM      = wr;
  assign if64.CSRAdrM        = adr;
  assign if64.CSRWriteValM   = wval;
  assign if64.PrivilegeModeM = priv;
  assign if32.CSRWriteM      = wr;
  assign if32.CSRAdrM        = adr;
  assign if32.CSRWriteValM   = wval[31:0];
  assign if32.PrivilegeModeM = priv;

  csr_counters #(.XLEN(64), .NUM_HPM(NHPM), .S_SUPPORTED(S_SUP), .U_SUPPORTED(U_SUP)) u64 (
    .clk(clk), .reset_n(reset_n), .csr(if64.slave),
    .MCOUNTINHIBIT_REGW(inhibit), .MCOUNTEREN_REGW(mcen), .SCOUNTEREN_REGW(scen),
    .InstrRetiredM(retired), .HPMEventM(ev));

  csr_counters #(.XLEN(32), .NUM_HPM(NHPM), .S_SUPPORTED(S_SUP), .U_SUPPORTED(U_SUP)) u32 (
    .clk(clk), .reset_n(reset_n), .csr(if32.slave),
    .MCOUNTINHIBIT_REGW(inhibit), .MCOUNTEREN_REGW(mcen), .SCOUNTEREN_REGW(scen),
    .InstrRetiredM(retired), .HPMEventM(ev));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic bit impl(input int i);
    return (i == 0) || (i == 2) || (i >= 3 && i < 3 + NHPM);
  endfunction

  function automatic bit m_illegal(input int xlen);
    int i;
    i = int'(adr[4:0]);
    if (!(adr[11:8] == 4'hB || (adr[11:8] == 4'hC && U_SUP))) return 1'b1;
    if (adr[6:5] != 2'b00) return 1'b1;
    if (i == 1) return 1'b1;
    if (adr[7] && xlen == 64) return 1'b1;
    if (adr[11:8] == 4'hB) return priv != 2'b11;
    if (wr) return 1'b1;
    if (priv == 2'b11) return 1'b0;
    if (priv == 2'b01) return !mcen[i];
    return !(mcen[i] && (S_SUP ? scen[i] : 1'b1));
  endfunction

  function automatic logic [63:0] m_read(input int xlen);
    int i;
    logic [63:0] v;
    i = int'(adr[4:0]);
    if (m_illegal(xlen) || !impl(i)) return 64'd0;
    v = (xlen == 64) ? m64[i] : m32[i];
    if (xlen == 64) return v;
    return adr[7] ? {32'd0, v[63:32]} : {32'd0, v[31:0]};
  endfunction

  function automatic logic [63:0] next_val(input int xlen, input int i, input logic [63:0] c);
    bit inc;
    if (i == 0)      inc = 1'b1;
    else if (i == 2) inc = retired;
    else             inc = ev[i-3];
    inc = inc && !inhibit[i];
    if (wr && adr[11:8] == 4'hB && int'(adr[4:0]) == i && !m_illegal(xlen)) begin
      if (xlen == 64) return wval;
      return adr[7] ? {wval[31:0], c[31:0]} : {c[63:32], wval[31:0]};
    end
    return c + (inc ? 64'd1 : 64'd0);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        m64[i] = 64'd0;
        m32[i] = 64'd0;
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (impl(i)) begin
          m64[i] = next_val(64, i, m64[i]);
          m32[i] = next_val(32, i, m32[i]);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("rd64",  if64.CSRCReadValM, m_read(64));
    chk("ill64", {63'd0, if64.IllegalCSRCAccessM}, {63'd0, m_illegal(64)});
    chk("rd32",  {32'd0, if32.CSRCReadValM}, m_read(32));
    chk("ill32", {63'd0, if32.IllegalCSRCAccessM}, {63'd0, m_illegal(32)});
  end

  // Literal expectation: checks both DUTs and the model against hand values.
  task automatic lit(input string name, input logic [11:0] a,
                     input logic [63:0] e64, input logic [31:0] e32,
                     input bit i64, input bit i32);
    adr = a;
    #1;
    chk({name, "_rd64"},  if64.CSRCReadValM, e64);
    chk({name, "_rd32"},  {32'd0, if32.CSRCReadValM}, {32'd0, e32});
    chk({name, "_ill64"}, {63'd0, if64.IllegalCSRCAccessM}, {63'd0, i64});
    chk({name, "_ill32"}, {63'd0, if32.IllegalCSRCAccessM}, {63'd0, i32});
    chk({name, "_mdl64"}, m_read(64), e64);
    chk({name, "_mdl32"}, m_read(32), {32'd0, e32});
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  logic [9:0] ret_pat;

  initial begin
    reset_n = 1'b0; wr = 1'b0; adr = 12'hB00; wval = '0; priv = 2'b11;
    inhibit = '0; mcen = '0; scen = '0; retired = 1'b0; ev = '0;
    ret_pat = 10'b0010100101;  // retires on cycles 0,2,5,7

    step(); step();
    reset_n = 1'b1;
    retired = ret_pat[0];
    for (int k = 1; k < 10; k++) begin
      step();
      retired = ret_pat[k];
    end
    step();
    retired = 1'b0;
    lit("cyc10", 12'hB00, 64'd10, 32'd10, 1'b0, 1'b0);
    lit("ret4",  12'hB02, 64'd4,  32'd4,  1'b0, 1'b0);

    // write all-ones to mcycle, then watch the wrap
    adr = 12'hB00; wval = 64'hFFFF_FFFF_FFFF_FFFF; wr = 1'b1;
    step();
    wr = 1'b0;
    lit("wr_ones",  12'hB00, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    lit("wr_hi0",   12'hB80, 64'd0, 32'd0, 1'b1, 1'b0);
    step();
    lit("wrap_lo",  12'hB00, 64'd0, 32'd0, 1'b0, 1'b0);
    lit("carry_hi", 12'hB80, 64'd0, 32'd1, 1'b1, 1'b0);

    // RV32 high-half write; low half held in the write cycle
    adr = 12'hB80; wval = 64'd5; wr = 1'b1;
    step();
    wr = 1'b0;
    lit("hi5",   12'hB80, 64'd0, 32'd5, 1'b1, 1'b0);
    lit("lo_hi", 12'hB00, 64'd1, 32'd0, 1'b0, 1'b0);

    // inhibit mcycle and minstret, pulse event 0 three times
    inhibit = 32'h5; retired = 1'b1;
    for (int s = 0; s < 20; s++) begin
      ev = (s == 3 || s == 7 || s == 11) ? 4'b0001 : 4'b0000;
      step();
    end
    ev = '0; retired = 1'b0;
    lit("inh_cyc", 12'hB00, 64'd1, 32'd0, 1'b0, 1'b0);
    lit("inh_ret", 12'hB02, 64'd4, 32'd4, 1'b0, 1'b0);
    lit("hpm3",    12'hB03, 64'd3, 32'd3, 1'b0, 1'b0);

    // user-mode shadow access control
    priv = 2'b00; mcen = 32'h4; scen = 32'h0;
    lit("u_deny",  12'hC02, 64'd0, 32'd0, 1'b1, 1'b1);
    scen = 32'h4;
    lit("u_allow", 12'hC02, 64'd4, 32'd4, 1'b0, 1'b0);

    // illegal writes leave state alone
    wr = 1'b1; wval = 64'h1234;
    lit("u_wr_c00", 12'hC00, 64'd0, 32'd0, 1'b1, 1'b1);
    step();
    priv = 2'b11;
    lit("m_wr_c00", 12'hC00, 64'd0, 32'd0, 1'b1, 1'b1);
    step();
    priv = 2'b01;
    lit("s_wr_b02", 12'hB02, 64'd0, 32'd0, 1'b1, 1'b1);
    step();
    wr = 1'b0; priv = 2'b11;
    lit("post_cyc", 12'hB00, 64'd1, 32'd0, 1'b0, 1'b0);
    lit("post_ret", 12'hB02, 64'd4, 32'd4, 1'b0, 1'b0);
    lit("unimpl",   12'hB1F, 64'd0, 32'd0, 1'b0, 1'b0);
    lit("time",     12'hB01, 64'd0, 32'd0, 1'b1, 1'b1);
    lit("out_map",  12'h300, 64'd0, 32'd0, 1'b1, 1'b1);

    // randomized phase, checked every cycle by the compare process
    for (int c = 0; c < 3000; c++) begin
      step();
      if ($urandom_range(0, 199) == 0) begin
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
      end
      case ($urandom_range(0, 3))
        0, 1:    priv = 2'b11;
        2:       priv = 2'b01;
        default: priv = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
      endcase
      if ($urandom_range(0, 15) == 0) adr = 12'($urandom);
      else begin
        adr[11:8] = $urandom_range(0, 1) ? 4'hB : 4'hC;
        adr[7:0]  = {($urandom_range(0, 3) == 0), 2'b00, 5'($urandom_range(0, 31))};
        if ($urandom_range(0, 2) != 0) adr[4:0] = 5'($urandom_range(0, 7));
      end
      wr = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 2))
        0:       wval = {$urandom, $urandom};
        1:       wval = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
        default: wval = {$urandom, 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))};
      endcase
      inhibit = $urandom & $urandom;
      mcen    = $urandom;
      scen    = $urandom;
      retired = 1'($urandom);
      ev      = 4'($urandom);
    end
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
